// File: rtl/program_loader.sv
// Instruction loader: packs op/rd/rs/imm fields into the 8-bit CPU encoding and
// writes them to sequential instruction-memory slots until HLT or an error.
module program_loader #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [1:0]        in_rd,
   input  logic [1:0]        in_rs,
   input  logic [3:0]        in_imm,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_wr_ack,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   instr_count
);

   typedef enum logic [2:0] {IDLE, RUN, WRITE, DONE, ERROR} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t              state, state_n;
   logic                wr_en_n, is_hlt, is_hlt_n, done_n, error_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [7:0]          wdata_n, enc;
   logic [1:0]          code_n, chk_code;
   logic [ADDR_W:0]     count_n, count_inc;

   assign in_ready  = (state == RUN);
   assign busy      = (state == RUN) || (state == WRITE);
   assign count_inc = instr_count + 1'b1;

   // MOV's destination shares bits with imm[3:2], so a mismatch is malformed.
   always_comb begin
      enc      = '0;
      chk_code = 2'b00;
      case (in_op)
         3'b000: begin
            enc = {4'b0000, in_imm};
            if (in_rd != in_imm[3:2]) chk_code = 2'b10;
         end
         3'b001, 3'b010: enc = {in_op, 1'b0, in_rd, in_rs};
         3'b111:         enc = 8'hE0;
         default:        chk_code = 2'b01;
      endcase
   end

   always_comb begin
      state_n  = state;
      wr_en_n  = mem_wr_en;
      addr_n   = mem_addr;
      wdata_n  = mem_wdata;
      is_hlt_n = is_hlt;
      done_n   = done;
      error_n  = error;
      code_n   = err_code;
      count_n  = instr_count;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_n = RUN;
               addr_n  = '0;
               count_n = '0;
               done_n  = 1'b0;
               error_n = 1'b0;
               code_n  = 2'b00;
            end
         end
         RUN: begin
            if (in_valid) begin
               if (chk_code == 2'b00) begin
                  wdata_n  = enc;
                  addr_n   = instr_count[ADDR_W-1:0];
                  wr_en_n  = 1'b1;
                  is_hlt_n = (in_op == 3'b111);
                  state_n  = WRITE;
               end else begin
                  code_n  = chk_code;
                  error_n = 1'b1;
                  state_n = ERROR;
               end
            end
         end
         WRITE: begin
            if (mem_wr_en && mem_wr_ack) begin
               wr_en_n = 1'b0;
               count_n = count_inc;
               if (is_hlt) begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end else if (count_inc == DEPTH_C) begin
                  error_n = 1'b1;
                  code_n  = 2'b11;
                  state_n = ERROR;
               end else begin
                  state_n = RUN;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mem_wr_en   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         is_hlt      <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_code    <= 2'b00;
         instr_count <= '0;
      end else begin
         state       <= state_n;
         mem_wr_en   <= wr_en_n;
         mem_addr    <= addr_n;
         mem_wdata   <= wdata_n;
         is_hlt      <= is_hlt_n;
         done        <= done_n;
         error       <= error_n;
         err_code    <= code_n;
         instr_count <= count_n;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-size instance and an ADDR_W=2
// instance share stimulus; sel picks which one is started and observed.
module tb_program_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, in_valid, sel;
   logic       ack = 1'b0;
   logic [2:0] in_op;
   logic [1:0] in_rd, in_rs;
   logic [3:0] in_imm;

   logic       rdy_l, wr_l, busy_l, done_l, err_l;
   logic [3:0] addr_l;
   logic [7:0] data_l;
   logic [1:0] code_l;
   logic [4:0] cnt_l;
   logic       rdy_s, wr_s, busy_s, done_s, err_s;
   logic [1:0] addr_s;
   logic [7:0] data_s;
   logic [1:0] code_s;
   logic [2:0] cnt_s;

   program_loader #(.ADDR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .in_valid(in_valid), .in_ready(rdy_l),
      .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm),
      .mem_wr_en(wr_l), .mem_addr(addr_l), .mem_wdata(data_l), .mem_wr_ack(ack),
      .busy(busy_l), .done(done_l), .error(err_l), .err_code(code_l), .instr_count(cnt_l));

   program_loader #(.ADDR_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .in_valid(in_valid), .in_ready(rdy_s),
      .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_imm(in_imm),
      .mem_wr_en(wr_s), .mem_addr(addr_s), .mem_wdata(data_s), .mem_wr_ack(ack),
      .busy(busy_s), .done(done_s), .error(err_s), .err_code(code_s), .instr_count(cnt_s));

   wire       o_ready = sel ? rdy_s  : rdy_l;
   wire       o_wr    = sel ? wr_s   : wr_l;
   wire [3:0] o_addr  = sel ? {2'b00, addr_s} : addr_l;
   wire [7:0] o_data  = sel ? data_s : data_l;
   wire       o_busy  = sel ? busy_s : busy_l;
   wire       o_done  = sel ? done_s : done_l;
   wire       o_err   = sel ? err_s  : err_l;
   wire [1:0] o_code  = sel ? code_s : code_l;
   wire [4:0] o_cnt   = sel ? {2'b00, cnt_s} : cnt_l;

   int checks = 0, failures = 0;
   int ack_delay = 0, wait_cnt = 0;
   bit ack_en = 1'b1;
   logic [3:0] log_addr[$];
   logic [7:0] log_data[$];
   int widths[$];
   int unstable = 0, overlap = 0, run_len = 0;
   logic [3:0] hold_addr = '0;
   logic [7:0] hold_data = '0;

   // Memory model: acks after ack_delay cycles of a held write request.
   always @(negedge clk) begin
      if (o_wr && ack_en) begin
         ack = (wait_cnt == ack_delay);
         wait_cnt++;
      end else begin
         ack = 1'b0;
         wait_cnt = 0;
      end
   end

   always @(posedge clk)
      if (o_wr && ack) begin
         log_addr.push_back(o_addr);
         log_data.push_back(o_data);
      end

   always @(negedge clk) begin
      if (o_ready && o_wr) overlap++;
      if (o_wr) begin
         if (run_len > 0 && (o_addr !== hold_addr || o_data !== hold_data)) unstable++;
         hold_addr = o_addr;
         hold_data = o_data;
         run_len++;
      end else if (run_len > 0) begin
         widths.push_back(run_len);
         run_len = 0;
      end
   end

   task automatic clear_logs();
      log_addr.delete(); log_data.delete(); widths.delete();
      unstable = 0; overlap = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [3:0] imm);
      bit ok = 1'b0;
      @(negedge clk);
      in_op = op; in_rd = rd; in_rs = rs; in_imm = imm; in_valid = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (o_ready) begin @(posedge clk); ok = 1'b1; end
         else @(negedge clk);
      end
      #1 in_valid = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL send_accept got=timeout exp=accepted op=%b", op); end
   endtask

   task automatic wait_end();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (o_done || o_err) ok = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (!ok) begin failures++; $display("FAIL wait_end got=timeout exp=done_or_error"); end
   endtask

   task automatic check_program_log();
      logic [7:0] exp_d[4] = '{8'h05, 8'h26, 8'h4C, 8'hE0};
      checks++;
      if (log_data.size() != 4) begin failures++; $display("FAIL prog_nwrites got=%0d exp=4", log_data.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (log_data[i] !== exp_d[i]) begin failures++; $display("FAIL prog_data[%0d] got=%h exp=%h", i, log_data[i], exp_d[i]); end
         if (log_addr[i] !== 4'(i)) begin failures++; $display("FAIL prog_addr[%0d] got=%0d exp=%0d", i, log_addr[i], i); end
      end
      checks += 4;
      if (o_done !== 1'b1) begin failures++; $display("FAIL prog_done got=%b exp=1", o_done); end
      if (o_cnt !== 5'd4) begin failures++; $display("FAIL prog_count got=%0d exp=4", o_cnt); end
      if (o_ready !== 1'b0) begin failures++; $display("FAIL prog_ready got=%b exp=0", o_ready); end
      if (o_err !== 1'b0) begin failures++; $display("FAIL prog_error got=%b exp=0", o_err); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks += 6;
      if (o_wr !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", o_wr); end
      if (o_addr !== 4'h0 || o_data !== 8'h00) begin failures++; $display("FAIL rst_addr_data got=%h/%h exp=0/00", o_addr, o_data); end
      if (o_done !== 1'b0 || o_err !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", o_done, o_err); end
      if (o_code !== 2'b00) begin failures++; $display("FAIL rst_err_code got=%b exp=00", o_code); end
      if (o_cnt !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", o_cnt); end
      if (o_ready !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL rst_ready_busy got=%b%b exp=00", o_ready, o_busy); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_program();
      clear_logs(); ack_delay = 0;
      pulse_start();
      send(3'b000, 2'd1, 2'd0, 4'b0101);
      checks += 2;
      if (o_wr !== 1'b1) begin failures++; $display("FAIL lat_wr_en got=%b exp=1", o_wr); end
      if (o_addr !== 4'h0 || o_data !== 8'h05) begin failures++; $display("FAIL lat_addr_data got=%h/%h exp=0/05", o_addr, o_data); end
      @(posedge clk); #1;
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL lat_back_to_run got=%b exp=1", o_ready); end
      send(3'b001, 2'd1, 2'd2, 4'h0);
      send(3'b010, 2'd3, 2'd0, 4'h0);
      send(3'b111, 2'd0, 2'd0, 4'h0);
      wait_end();
      check_program_log();
   endtask

   task automatic test_backpressure();
      clear_logs(); ack_delay = 3;
      pulse_start();
      send(3'b000, 2'd1, 2'd0, 4'b0101);
      send(3'b001, 2'd1, 2'd2, 4'h0);
      send(3'b010, 2'd3, 2'd0, 4'h0);
      send(3'b111, 2'd0, 2'd0, 4'h0);
      wait_end();
      check_program_log();
      checks += 3;
      if (widths.size() != 4) begin failures++; $display("FAIL bp_nbursts got=%0d exp=4", widths.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++;
         if (widths[i] != 4) begin failures++; $display("FAIL bp_width[%0d] got=%0d exp=4", i, widths[i]); end
      end
      if (unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
      if (overlap != 0) begin failures++; $display("FAIL bp_accept_during_write got=%0d exp=0", overlap); end
      ack_delay = 0;
   endtask

   task automatic test_illegal_opcode();
      clear_logs();
      pulse_start();
      send(3'b000, 2'd0, 2'd0, 4'b0011);
      send(3'b100, 2'd0, 2'd0, 4'h0);
      wait_end();
      repeat (5) @(negedge clk);
      checks += 5;
      if (o_err !== 1'b1 || o_code !== 2'b01) begin failures++; $display("FAIL ill_error got=%b/%b exp=1/01", o_err, o_code); end
      if (o_cnt !== 5'd1) begin failures++; $display("FAIL ill_count got=%0d exp=1", o_cnt); end
      if (log_data.size() != 1) begin failures++; $display("FAIL ill_nwrites got=%0d exp=1", log_data.size()); end
      else if (log_data[0] !== 8'h03 || log_addr[0] !== 4'h0) begin failures++; $display("FAIL ill_write got=%h@%0d exp=03@0", log_data[0], log_addr[0]); end
      if (o_wr !== 1'b0) begin failures++; $display("FAIL ill_wr_en got=%b exp=0", o_wr); end
      if (o_done !== 1'b0) begin failures++; $display("FAIL ill_done got=%b exp=0", o_done); end
   endtask

   task automatic test_mov_conflict();
      clear_logs();
      pulse_start();
      send(3'b000, 2'd2, 2'd0, 4'b0101);
      wait_end();
      checks += 3;
      if (o_err !== 1'b1 || o_code !== 2'b10) begin failures++; $display("FAIL mov_error got=%b/%b exp=1/10", o_err, o_code); end
      if (log_data.size() != 0) begin failures++; $display("FAIL mov_nwrites got=%0d exp=0", log_data.size()); end
      if (o_cnt !== 5'd0) begin failures++; $display("FAIL mov_count got=%0d exp=0", o_cnt); end
   endtask

   task automatic test_mem_full();
      sel = 1'b1;
      clear_logs();
      pulse_start();
      for (int i = 0; i < 4; i++) send(3'b001, 2'(i), 2'd0, 4'h0);
      wait_end();
      checks += 3;
      if (o_err !== 1'b1 || o_code !== 2'b11) begin failures++; $display("FAIL full_error got=%b/%b exp=1/11", o_err, o_code); end
      if (o_cnt !== 5'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", o_cnt); end
      if (o_done !== 1'b0) begin failures++; $display("FAIL full_done got=%b exp=0", o_done); end
      clear_logs();
      pulse_start();
      for (int i = 0; i < 3; i++) send(3'b001, 2'(i), 2'd1, 4'h0);
      send(3'b111, 2'd0, 2'd0, 4'h0);
      wait_end();
      checks += 3;
      if (log_data.size() != 4) begin failures++; $display("FAIL last_nwrites got=%0d exp=4", log_data.size()); end
      else if (log_addr[3] !== 4'd3 || log_data[3] !== 8'hE0) begin failures++; $display("FAIL last_hlt got=%h@%0d exp=E0@3", log_data[3], log_addr[3]); end
      if (o_done !== 1'b1 || o_err !== 1'b0) begin failures++; $display("FAIL last_flags got=%b%b exp=10", o_done, o_err); end
      if (o_code !== 2'b00) begin failures++; $display("FAIL last_err_code got=%b exp=00", o_code); end
      sel = 1'b0;
   endtask

   task automatic test_reset_restart();
      bit seen = 1'b0;
      clear_logs();
      pulse_start();
      send(3'b001, 2'd1, 2'd1, 4'h0);
      @(posedge clk); #1;
      ack_en = 1'b0;
      send(3'b000, 2'd3, 2'd0, 4'hF);
      @(posedge clk); #2;
      checks++;
      if (o_wr !== 1'b1 || o_addr !== 4'd1 || o_data !== 8'h0F) begin failures++; $display("FAIL pend_write got=%b %h@%0d exp=1 0F@1", o_wr, o_data, o_addr); end
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (o_wr !== 1'b0) begin failures++; $display("FAIL arst_wr_en got=%b exp=0", o_wr); end
      if (o_addr !== 4'h0 || o_data !== 8'h00) begin failures++; $display("FAIL arst_addr_data got=%h/%h exp=0/00", o_addr, o_data); end
      if (o_cnt !== 5'd0 || o_busy !== 1'b0) begin failures++; $display("FAIL arst_count_busy got=%0d/%b exp=0/0", o_cnt, o_busy); end
      if (o_done !== 1'b0 || o_err !== 1'b0 || o_code !== 2'b00) begin failures++; $display("FAIL arst_flags got=%b%b%b exp=0000", o_done, o_err, o_code); end
      @(negedge clk); rst_n = 1'b1; ack_en = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (o_wr !== 1'b0 || log_data.size() != 1) begin failures++; $display("FAIL arst_abandon got=%b/%0d exp=0/1", o_wr, log_data.size()); end

      // Start pulses in WRITE and in RUN must not restart the load.
      clear_logs(); ack_delay = 3;
      pulse_start();
      send(3'b001, 2'd0, 2'd1, 4'h0);
      pulse_start();
      for (int i = 0; i < 40 && !seen; i++) begin
         if (o_ready) seen = 1'b1;
         else @(negedge clk);
      end
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      send(3'b111, 2'd0, 2'd0, 4'h0);
      wait_end();
      checks += 3;
      if (o_cnt !== 5'd2 || o_done !== 1'b1) begin failures++; $display("FAIL busy_start_count got=%0d/%b exp=2/1", o_cnt, o_done); end
      if (log_data.size() != 2) begin failures++; $display("FAIL busy_start_nwrites got=%0d exp=2", log_data.size()); end
      else if (log_data[0] !== 8'h21 || log_addr[1] !== 4'd1 || log_data[1] !== 8'hE0) begin
         failures++; $display("FAIL busy_start_writes got=%h@0 %h@%0d exp=21@0 E0@1", log_data[0], log_data[1], log_addr[1]);
      end
      if (o_err !== 1'b0) begin failures++; $display("FAIL busy_start_error got=%b exp=0", o_err); end

      clear_logs(); ack_delay = 0;
      pulse_start();
      checks++;
      if (o_done !== 1'b0 || o_cnt !== 5'd0 || o_ready !== 1'b1 || o_busy !== 1'b1) begin
         failures++; $display("FAIL restart_state got=done%b cnt%0d rdy%b busy%b exp=done0 cnt0 rdy1 busy1", o_done, o_cnt, o_ready, o_busy);
      end
      send(3'b000, 2'd2, 2'd0, 4'b1010);
      send(3'b111, 2'd0, 2'd0, 4'h0);
      wait_end();
      checks += 2;
      if (log_data.size() != 2) begin failures++; $display("FAIL restart_nwrites got=%0d exp=2", log_data.size()); end
      else if (log_addr[0] !== 4'd0 || log_data[0] !== 8'h0A) begin failures++; $display("FAIL restart_first got=%h@%0d exp=0A@0", log_data[0], log_addr[0]); end
      if (o_cnt !== 5'd2 || o_done !== 1'b1) begin failures++; $display("FAIL restart_count got=%0d/%b exp=2/1", o_cnt, o_done); end
   endtask

   initial begin
      sel = 1'b0; start = 1'b0; in_valid = 1'b0;
      in_op = '0; in_rd = '0; in_rs = '0; in_imm = '0;
      test_reset();
      test_program();
      test_backpressure();
      test_illegal_opcode();
      test_mov_conflict();
      test_mem_full();
      test_reset_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
